// File: rtl/bram_stream_reader.sv
// Read-side client for the simple dual-port block RAM: issues a burst of reads and
// re-times the one-cycle RAM latency through a 2-entry buffer into a valid/ready stream.
module bram_stream_reader #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 28
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  localparam int              CW      = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]   CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [CW-1:0]         r_len;
  logic [CW-1:0]         r_issued;
  logic [CW-1:0]         r_sent;
  logic                  r_inflight;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] r_mem [2];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;

  logic                  w_valid;
  logic                  w_pop;
  logic                  w_last_beat;
  logic                  w_accept;
  logic [2:0]            w_occ;
  logic                  w_rd_en;

  assign w_valid     = (r_count != 2'd0);
  assign w_pop       = w_valid & m_ready;
  assign w_last_beat = (r_sent == (r_len - CNT_ONE));
  assign w_accept    = (r_state == S_IDLE) & start;
  // Occupancy after this cycle: buffered words plus the read landing next cycle.
  assign w_occ       = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_rd_en     = (r_state == S_RUN) && (r_issued < r_len) && (w_occ < 3'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start && (length != {CW{1'b0}})) w_state_nxt = S_RUN;
        else                                 w_state_nxt = S_IDLE;
      end
      S_RUN: begin
        if (w_pop && w_last_beat) w_state_nxt = S_IDLE;
        else                      w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (r_state == S_RUN);
    done    = r_done;
    rd_en   = w_rd_en;
    rd_addr = r_base + r_issued[ADDR_WIDTH-1:0];
    m_valid = w_valid;
    m_last  = w_valid & w_last_beat;
    if (w_valid) m_data = r_mem[r_rd_ptr];
    else         m_data = {DATA_WIDTH{1'b0}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base     <= {ADDR_WIDTH{1'b0}};
      r_len      <= {CW{1'b0}};
      r_issued   <= {CW{1'b0}};
      r_sent     <= {CW{1'b0}};
      r_inflight <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_inflight <= w_rd_en;
      r_done     <= (w_accept && (length == {CW{1'b0}})) ||
                    ((r_state == S_RUN) && w_pop && w_last_beat);
      if (w_accept) begin
        r_base   <= base_addr;
        r_len    <= length;
        r_issued <= {CW{1'b0}};
        r_sent   <= {CW{1'b0}};
      end else begin
        if (w_rd_en) r_issued <= r_issued + CNT_ONE;
        if (w_pop)   r_sent   <= r_sent + CNT_ONE;
      end
    end
  end

  // Two-entry FIFO absorbing the RAM read latency; the issue rule prevents overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= {DATA_WIDTH{1'b0}};
      r_mem[1] <= {DATA_WIDTH{1'b0}};
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (r_inflight) begin
        r_mem[r_wr_ptr] <= rd_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a RAM model holding mem[a]=a.
module tb_bram_stream_reader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [14:0] base_addr;
  logic [15:0] length;
  logic        busy;
  logic        done;
  logic        rd_en;
  logic [14:0] rd_addr;
  logic [27:0] rd_data;
  logic        m_valid;
  logic        m_ready;
  logic [27:0] m_data;
  logic        m_last;

  int n_chk = 0;
  int n_err = 0;

  bram_stream_reader #(.ADDR_WIDTH(15), .DATA_WIDTH(28)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial rd_data = 28'd0;
  always @(posedge clk) if (rd_en) rd_data <= {13'd0, rd_addr};

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc_begin();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_sample();
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"},    busy,    0);
    check_eq({tag, "_done"},    done,    0);
    check_eq({tag, "_rd_en"},   rd_en,   0);
    check_eq({tag, "_rd_addr"}, rd_addr, 0);
    check_eq({tag, "_m_valid"}, m_valid, 0);
    check_eq({tag, "_m_data"},  m_data,  0);
    check_eq({tag, "_m_last"},  m_last,  0);
  endtask

  // Runs one command, checking every cycle until done; cycle 0 is the start cycle.
  task automatic run_cmd(input logic [14:0] base, input logic [15:0] len, input logic [63:0] rpat,
                         input int ign_cyc, input int chain_cyc, input logic [14:0] nbase,
                         input logic [15:0] nlen, input bit pre,
                         output int done_c, output int rd_c, output int val_c);
    int n_iss, n_rcv, buf_n, infl, pop;
    bit fin;
    logic [14:0] ea;
    n_iss = 0; n_rcv = 0; buf_n = 0; infl = 0; fin = 0;
    done_c = -1; rd_c = -1; val_c = -1;
    if (!pre) begin
      cyc_begin();
      start = 1'b1; base_addr = base; length = len; m_ready = rpat[0];
      cyc_sample();
      check_eq("idle_busy", busy, 0);
    end
    for (int c = 1; c < 300 && !fin; c++) begin
      cyc_begin();
      start   = 1'b0;
      m_ready = (c < 64) ? rpat[c] : 1'b1;
      if (c == ign_cyc) begin
        start = 1'b1; base_addr = base + 15'h0100; length = 16'd5;
      end
      if (c == chain_cyc) begin
        start = 1'b1; base_addr = nbase; length = nlen;
      end
      cyc_sample();
      pop = (m_valid && m_ready) ? 1 : 0;
      if (done) begin
        check_eq("done_count", n_rcv, len);
        check_eq("done_busy", busy, 0);
        check_eq("done_valid", m_valid, 0);
        done_c = c;
        fin = 1;
      end else begin
        check_eq("busy", busy, n_rcv < len);
      end
      if (rd_en) begin
        if (rd_c < 0) rd_c = c;
        check_eq("rd_over", n_iss < len, 1);
        ea = base + n_iss[14:0];
        check_eq("rd_addr", rd_addr, ea);
        check_eq("occupancy", (buf_n + infl - pop) < 2, 1);
        n_iss++;
      end
      if (m_valid) begin
        if (val_c < 0) val_c = c;
        check_eq("beat_over", n_rcv < len, 1);
        ea = base + n_rcv[14:0];
        check_eq("m_data", m_data, {13'd0, ea});
        check_eq("m_last", m_last, n_rcv == len - 1);
        if (m_ready) n_rcv++;
      end else begin
        check_eq("m_last_idle", m_last, 0);
      end
      buf_n = buf_n + infl - pop;
      infl  = rd_en ? 1 : 0;
    end
    if (!fin) check_eq("timeout", 0, 1);
  endtask

  initial begin
    logic [63:0] all1;
    logic [63:0] bp;
    int dc, rc, vc;
    all1 = 64'hFFFF_FFFF_FFFF_FFFF;
    bp   = 64'hFFFF_FFFF_FFED_002F;
    rst_n = 1'b0; start = 1'b0; base_addr = 15'd0; length = 16'd0; m_ready = 1'b0;
    #3;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    run_cmd(15'h0010, 16'd4, all1, -1, -1, 15'd0, 16'd0, 1'b0, dc, rc, vc);
    check_eq("basic_done_cycle", dc, 7);
    check_eq("basic_first_rd", rc, 1);
    check_eq("basic_first_valid", vc, 3);
    cyc_begin();
    cyc_sample();
    check_eq("basic_done_once", done, 0);

    run_cmd(15'h7FFE, 16'd4, all1, -1, -1, 15'd0, 16'd0, 1'b0, dc, rc, vc);
    check_eq("wrap_done_cycle", dc, 7);

    run_cmd(15'h0200, 16'd8, bp, -1, -1, 15'd0, 16'd0, 1'b0, dc, rc, vc);
    check_eq("bp_done_seen", dc > 0, 1);

    run_cmd(15'h0300, 16'd0, all1, -1, -1, 15'd0, 16'd0, 1'b0, dc, rc, vc);
    check_eq("len0_done_cycle", dc, 1);
    check_eq("len0_no_rd", rc < 0, 1);
    check_eq("len0_no_valid", vc < 0, 1);

    run_cmd(15'h0400, 16'd3, all1, 2, 6, 15'h0500, 16'd2, 1'b0, dc, rc, vc);
    check_eq("ovl_done_cycle", dc, 6);
    run_cmd(15'h0500, 16'd2, all1, -1, -1, 15'd0, 16'd0, 1'b1, dc, rc, vc);
    check_eq("chain_first_rd", rc, 1);
    check_eq("chain_done_cycle", dc, 5);

    cyc_begin();
    start = 1'b1; base_addr = 15'h0020; length = 16'd8; m_ready = 1'b1;
    cyc_sample();
    for (int c = 1; c <= 5; c++) begin
      cyc_begin();
      start = 1'b0;
      cyc_sample();
    end
    check_eq("pre_rst_valid", m_valid, 1);
    check_eq("pre_rst_data", m_data, 28'h22);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cyc_begin();
      cyc_sample();
      check_eq("post_rst_done", done, 0);
      check_eq("post_rst_valid", m_valid, 0);
      check_eq("post_rst_busy", busy, 0);
    end
    run_cmd(15'h0040, 16'd2, all1, -1, -1, 15'd0, 16'd0, 1'b0, dc, rc, vc);
    check_eq("post_rst_done_cycle", dc, 5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/bram_stream_reader.md
# bram_stream_reader

Read-side client for the team's simple dual-port block RAM. It accepts a base address and a word count, issues `rd_en`/`rd_addr` to the RAM read port, and absorbs the RAM's one-cycle registered read latency in a 2-entry output buffer. It emits the words as a valid/ready stream with a last-beat marker, so downstream compute units can consume stored activations or weights at one word per cycle under backpressure.

## Interface
- `ADDR_WIDTH`, 15, RAM address width; the RAM holds 2**ADDR_WIDTH words.
- `DATA_WIDTH`, 28, RAM and stream word width (7 bit x 4 lanes).

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  command strobe; accepted only while `busy`=0.
- `base_addr`  in  ADDR_WIDTH  first word address; sampled with `start`.
- `length`  in  ADDR_WIDTH+1  word count, 0 to 2**ADDR_WIDTH; sampled with `start`.
- `busy`  out  1  a command is in progress.
- `done`  out  1  one-cycle pulse when the command completes.
- `rd_en`  out  1  RAM read enable.
- `rd_addr`  out  ADDR_WIDTH  RAM read address.
- `rd_data`  in  DATA_WIDTH  RAM registered read data; valid the cycle after `rd_en`.
- `m_valid`  out  1  stream word valid.
- `m_ready`  in  1  downstream accepts the word.
- `m_data`  out  DATA_WIDTH  stream word.
- `m_last`  out  1  high with the final word of a command.

## Operation
- States:
  - IDLE: `start`=1 latches `base_addr`, `length`, sets issued=0 and sent=0, and moves to RUN. If `length`=0, it instead pulses `done` next cycle and stays in IDLE.
  - RUN: issues reads and drains the buffer.
  - RUN to IDLE: on the handshake (`m_valid`&&`m_ready`) of beat number `length`-1. `done` pulses the following cycle.
- Read issue rule, per cycle:
  - Assert `rd_en` iff state=RUN, issued<`length`, and (buf_count + inflight − pop) < 2.
  - inflight = `rd_en` of the previous cycle. pop = the current-cycle handshake.
  - `rd_addr` = (base + issued) mod 2**ADDR_WIDTH, so addresses wrap past the top.
  - `rd_en`=0 leaves `rd_addr` don't-care. The bench checks it only when `rd_en`=1.
- Capture: when inflight=1, `rd_data` is written into the 2-entry FIFO that same cycle. The issue rule guarantees the FIFO never overflows. The FIFO is first-word-first-out.
- Stream output:
  - `m_valid` = FIFO non-empty; `m_data` = FIFO head.
  - `m_last` = `m_valid` && (sent == `length`−1).
  - While `m_valid`=1 and `m_ready`=0, `m_data`/`m_last` stay stable.
- `busy`: 1 from the cycle after `start` is accepted through the cycle of the final handshake, inclusive. It is 0 in the `done` cycle.
- `start` while `busy`=1 is ignored. A `start` in the `done` cycle is accepted.
- Widths: issued and sent counters are ADDR_WIDTH+1 bits, which handles `length`=2**ADDR_WIDTH.

## Timing
- Reset (async assert, any state): state=IDLE, FIFO empty, inflight cleared. All outputs go to 0: `busy`, `done`, `rd_en`, `rd_addr`, `m_valid`, `m_data`, `m_last`.
- Reset mid-command: any in-flight read data is discarded. No `done` is produced.
- First-word latency with `m_ready`=1 (`start` in cycle 0):
  - cycle 1: `rd_en`=1, `rd_addr`=base.
  - cycle 2: `rd_data` is written into the FIFO.
  - cycle 3: `m_valid`=1.
- Throughput: with `m_ready` held at 1, one word per cycle. N words end at cycle N+2, and `done` pulses in cycle N+3.
- Backpressure: at most 2 words are buffered plus 0 in flight, or 1 buffered plus 1 in flight. `rd_en` stalls within 1 cycle of `m_ready` falling. No word is lost or duplicated.

## Test plan
- RAM preloaded with mem[a]=a. `start` with base=0x10, length=4, `m_ready`=1:
  - `m_data` = 0x10, 0x11, 0x12, 0x13 in cycles 3–6.
  - `m_last` only on 0x13.
  - `done` pulses in cycle 7; `busy` is 0 in cycle 7.
- Wrap: base=0x7FFE, length=4 (ADDR_WIDTH=15):
  - `rd_addr` sequence is 0x7FFE, 0x7FFF, 0x0000, 0x0001.
  - Words arrive in that order.
- Backpressure: length=8, `m_ready` toggling with a pseudo-random pattern, including a 10-cycle hold-low:
  - Exactly 8 words are received, in order, with no gaps or duplicates.
  - `m_data` is stable during stalls.
  - `rd_en` never pushes buffered plus in-flight occupancy past 2.
- length=0:
  - `done` pulses the cycle after `start`.
  - `busy`, `rd_en` and `m_valid` never assert.
- Command overlap: a second `start` while `busy` is ignored. A `start` in the `done` cycle launches a new command, and its first `rd_en` appears the next cycle.
- Reset mid-stream: `rst_n` low during beat 3 of length=8.
  - All outputs are 0 immediately.
  - After release, a new length=2 command produces exactly 2 correct words.
